// File: rtl/filter_frame_arbiter.sv
// Round-robin frame arbiter feeding a 3x3 filter from two window streams.
// Optional frame watchdog enabled with `define FRAME_ARB_WDOG_EN.
module filter_frame_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s0_val,
  input  logic [9*DATA_WIDTH-1:0] s0_data,
  input  logic                    s0_sof,
  input  logic                    s0_sol,
  input  logic                    s0_eol,
  input  logic                    s0_eof,
  output logic                    s0_rdy,
  input  logic                    s1_val,
  input  logic [9*DATA_WIDTH-1:0] s1_data,
  input  logic                    s1_sof,
  input  logic                    s1_sol,
  input  logic                    s1_eol,
  input  logic                    s1_eof,
  output logic                    s1_rdy,
  output logic                    m_val,
  output logic [9*DATA_WIDTH-1:0] m_data,
  output logic                    m_sof,
  output logic                    m_sol,
  output logic                    m_eol,
  output logic                    m_eof,
  input  logic                    m_rdy,
  output logic [1:0]              gnt,
  output logic                    wdog_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state;
  logic   last_w;
  logic   accept;
  logic   elig0, elig1, pick1;
  logic   wdog_hit;

  assign elig0  = s0_val & s0_sof;
  assign elig1  = s1_val & s1_sof;
  // last_w = 1 means source 1 won last, so source 0 takes a tie.
  assign pick1  = elig1 & (~elig0 | ~last_w);
  assign accept = m_val & m_rdy;

  always_comb begin
    s0_rdy = 1'b0;
    s1_rdy = 1'b0;
    m_val  = 1'b0;
    m_data = '0;
    m_sof  = 1'b0;
    m_sol  = 1'b0;
    m_eol  = 1'b0;
    m_eof  = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          // Non-sof beats are drained so a partial frame cannot block arbitration.
          s0_rdy = s0_val & ~s0_sof;
          s1_rdy = s1_val & ~s1_sof;
        end
        GNT0: begin
          m_val  = s0_val;
          m_data = s0_data;
          m_sof  = s0_sof;
          m_sol  = s0_sol;
          m_eol  = s0_eol;
          m_eof  = s0_eof;
          s0_rdy = m_rdy;
        end
        GNT1: begin
          m_val  = s1_val;
          m_data = s1_data;
          m_sof  = s1_sof;
          m_sol  = s1_sol;
          m_eol  = s1_eol;
          m_eof  = s1_eof;
          s1_rdy = m_rdy;
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_ARB_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        wdog_err_q;

  assign wdog_hit = (state != IDLE) & ~accept &
                    (wdog_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign wdog_err = wdog_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_err_q <= wdog_hit;
      if (state == IDLE || accept || wdog_hit)
        wdog_cnt <= '0;
      else
        wdog_cnt <= wdog_cnt + 16'd1;
    end
  end
`else
  logic wdog_unused;

  assign wdog_unused = ^TIMEOUT_CYCLES;
  assign wdog_hit    = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= 2'b00;
      last_w <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            state <= pick1 ? GNT1 : GNT0;
            gnt   <= pick1 ? 2'b10 : 2'b01;
          end
        end
        GNT0, GNT1: begin
          if ((accept & m_eof) | wdog_hit) begin
            state  <= IDLE;
            gnt    <= 2'b00;
            last_w <= (state == GNT1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_frame_arbiter.sv
// Randomized and directed bench for filter_frame_arbiter against a frame-level
// ownership model; watchdog expectations follow FRAME_ARB_WDOG_EN.
module tb_filter_frame_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 9 * DW;
  localparam int unsigned TO = 8;
`ifdef FRAME_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  typedef struct packed {
    logic         sof;
    logic         sol;
    logic         eol;
    logic         eof;
    logic [W-1:0] d;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [1:0]   val, sof, sol, eol, eof;
  logic [W-1:0] dat [2];
  logic         s0_rdy, s1_rdy;
  logic         m_val, m_sof, m_sol, m_eol, m_eof, m_rdy;
  logic [W-1:0] m_data;
  logic [1:0]   gnt;
  logic         wdog_err;

  filter_frame_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_val(val[0]), .s0_data(dat[0]), .s0_sof(sof[0]), .s0_sol(sol[0]),
    .s0_eol(eol[0]), .s0_eof(eof[0]), .s0_rdy(s0_rdy),
    .s1_val(val[1]), .s1_data(dat[1]), .s1_sof(sof[1]), .s1_sol(sol[1]),
    .s1_eol(eol[1]), .s1_eof(eof[1]), .s1_rdy(s1_rdy),
    .m_val(m_val), .m_data(m_data), .m_sof(m_sof), .m_sol(m_sol),
    .m_eol(m_eol), .m_eof(m_eof), .m_rdy(m_rdy),
    .gnt(gnt), .wdog_err(wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: who owns the filter, who owned it last, idle time, pending error pulse.
  int owner = -1;
  int lastw = 1;
  int idle_cnt = 0;
  bit err_q = 1'b0;

  beat_t q0[$];
  beat_t q1[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic beat_t mk(input bit f_sof, input bit f_eof);
    beat_t b;
    b.sof = f_sof;
    b.sol = 1'($urandom_range(0, 1));
    b.eol = 1'($urandom_range(0, 1));
    b.eof = f_eof;
    b.d   = W'({$urandom(), $urandom(), $urandom()});
    return b;
  endfunction

  task automatic push_frame(input int s, input int len);
    for (int i = 0; i < len; i++) begin
      if (s == 0) q0.push_back(mk(i == 0, i == len - 1));
      else        q1.push_back(mk(i == 0, i == len - 1));
    end
  endtask

  task automatic push_junk(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      if (s == 0) q0.push_back(mk(1'b0, 1'($urandom_range(0, 1))));
      else        q1.push_back(mk(1'b0, 1'($urandom_range(0, 1))));
    end
  endtask

  // One clock cycle: drive queue heads, compare against the model, advance the model.
  task automatic step(input bit en0, input bit en1, input bit mr);
    beat_t      h [2];
    logic [1:0] e_gnt, e_rdy;
    logic       e_mval;
    logic [3:0] e_fl;
    bit         el0, el1, acc;
    h[0] = (q0.size() != 0) ? q0[0] : '0;
    h[1] = (q1.size() != 0) ? q1[0] : '0;
    val[0] = en0 && (q0.size() != 0);
    val[1] = en1 && (q1.size() != 0);
    for (int s = 0; s < 2; s++) begin
      sof[s] = h[s].sof; sol[s] = h[s].sol; eol[s] = h[s].eol; eof[s] = h[s].eof;
      dat[s] = h[s].d;
    end
    m_rdy = mr;
    #3;
    e_gnt  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_rdy  = '0;
    e_mval = 1'b0;
    e_fl   = '0;
    if (rst_n) begin
      if (owner < 0) begin
        for (int s = 0; s < 2; s++) e_rdy[s] = val[s] & ~sof[s];
      end else begin
        e_mval       = val[owner];
        e_fl         = {sof[owner], sol[owner], eol[owner], eof[owner]};
        e_rdy[owner] = mr;
      end
    end
    check("gnt", gnt, e_gnt);
    check("wdog_err", wdog_err, err_q);
    check("m_val", m_val, e_mval);
    check("m_flags", {m_sof, m_sol, m_eol, m_eof}, e_fl);
    check("s0_rdy", s0_rdy, e_rdy[0]);
    check("s1_rdy", s1_rdy, e_rdy[1]);
    if (rst_n && owner >= 0) check("m_data", m_data, dat[owner]);
    if (val[0] && s0_rdy) void'(q0.pop_front());
    if (val[1] && s1_rdy) void'(q1.pop_front());
    if (!rst_n) begin
      owner = -1; lastw = 1; idle_cnt = 0; err_q = 1'b0;
    end else if (owner < 0) begin
      err_q = 1'b0; idle_cnt = 0;
      el0 = val[0] && sof[0];
      el1 = val[1] && sof[1];
      if (el0 && el1) owner = 1 - lastw;
      else if (el0)   owner = 0;
      else if (el1)   owner = 1;
    end else begin
      err_q = 1'b0;
      acc = val[owner] && mr;
      if (acc && eof[owner]) begin
        lastw = owner; owner = -1;
      end else if (acc) begin
        idle_cnt = 0;
      end else if (WDOG && idle_cnt == int'(TO) - 1) begin
        lastw = owner; owner = -1; err_q = 1'b1;
      end else begin
        idle_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) step(1'b1, 1'b1, 1'b1);
    check("drain", q0.size() + q1.size(), 0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; val = '0; sof = '0; sol = '0; eol = '0; eof = '0; m_rdy = 1'b0;
    dat[0] = '0; dat[1] = '0;
    @(posedge clk);
    #1;

    // Reset state, held with both sources offering sof.
    push_frame(0, 4);
    push_frame(1, 3);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_gnt", gnt, 2'b00);
    check("rst_held", q0.size() + q1.size(), 7);

    // Simultaneous sof after reset: source 0 first, then source 1.
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    check("rr_first", gnt, 2'b01);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    check("rr_release", gnt, 2'b00);
    step(1'b1, 1'b1, 1'b1);
    check("rr_second", gnt, 2'b10);
    drain();
    step(1'b1, 1'b1, 1'b1);

    // Flush of sof-less beats in IDLE, then a real s1 frame.
    push_junk(1, 3);
    push_frame(1, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    check("flush_cnt", q1.size(), 2);
    check("flush_gnt", gnt, 2'b00);
    step(1'b0, 1'b1, 1'b1);
    check("flush_then_gnt", gnt, 2'b10);
    drain();

    // m_rdy toggling 1,0,1 across a 2-beat s0 frame while s1 waits.
    push_frame(0, 2);
    push_frame(1, 2);
    step(1'b1, 1'b1, 1'b1);
    check("bp_gnt", gnt, 2'b01);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("bp_hold", gnt, 2'b01);
    step(1'b1, 1'b1, 1'b1);
    check("bp_release", gnt, 2'b00);
    check("bp_s0_done", q0.size(), 0);
    drain();

    // One-cycle reset in the middle of an s0 frame.
    push_frame(0, 5);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    check("midrst_gnt", gnt, 2'b00);
    check("midrst_left", q0.size(), 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("midrst_flushed", q0.size(), 0);

    // s0 stalls after its sof.
    push_frame(0, 3);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 1'b1);
      if (wdog_err === 1'b1 && seen == 0) seen = k;
    end
    check("wdog_latency", seen, WDOG ? 8 : 0);
    check("stall_gnt", gnt, WDOG ? 2'b00 : 2'b01);
    drain();

    // Randomized traffic with backpressure, gaps, 1-beat frames and rare resets.
    for (int c = 0; c < 3000; c++) begin
      if (q0.size() < 2) begin
        if ($urandom_range(0, 6) == 0) push_junk(0, $urandom_range(1, 3));
        else push_frame(0, $urandom_range(1, 6));
      end
      if (q1.size() < 2) begin
        if ($urandom_range(0, 6) == 0) push_junk(1, $urandom_range(1, 3));
        else push_frame(1, $urandom_range(1, 6));
      end
      rst_n = ($urandom_range(0, 399) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end
    rst_n = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
